// File: rtl/spu_issue_scheduler.sv
// Dual-issue scheduler with a per-register latency scoreboard between decode and ID/REG.
// Define SPU_SCHED_DUAL_ISSUE_EN to let both slots of a pair issue in the same cycle.
module spu_issue_scheduler #(
    parameter int unsigned NREG = 128,
    parameter int unsigned LATW = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    s0_pipe,
    input  logic [$clog2(NREG)-1:0] s0_ra,
    input  logic [$clog2(NREG)-1:0] s0_rb,
    input  logic [$clog2(NREG)-1:0] s0_rc,
    input  logic [$clog2(NREG)-1:0] s0_rt,
    input  logic                    s0_use_ra,
    input  logic                    s0_use_rb,
    input  logic                    s0_use_rc,
    input  logic                    s0_wr,
    input  logic [LATW-1:0]         s0_lat,
    input  logic                    s1_pipe,
    input  logic [$clog2(NREG)-1:0] s1_ra,
    input  logic [$clog2(NREG)-1:0] s1_rb,
    input  logic [$clog2(NREG)-1:0] s1_rc,
    input  logic [$clog2(NREG)-1:0] s1_rt,
    input  logic                    s1_use_ra,
    input  logic                    s1_use_rb,
    input  logic                    s1_use_rc,
    input  logic                    s1_wr,
    input  logic [LATW-1:0]         s1_lat,
    output logic                    even_issue,
    output logic                    even_slot,
    output logic                    odd_issue,
    output logic                    odd_slot
);
    localparam int unsigned AW = $clog2(NREG);

    typedef enum logic {
        FULL   = 1'b0,
        SECOND = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [LATW-1:0] cnt_q [NREG];
    logic [LATW-1:0] cnt_d [NREG];
    logic            srcok0, srcok1, pair_ok;
    logic            iss0, iss1;
    logic [LATW-1:0] lat0, lat1;

    // A counter of 1 expires at this edge, so the result is forwardable to a reader issuing now.
    function automatic logic src_ready(input logic use_r, input logic [AW-1:0] r);
        return !use_r || (cnt_q[r] <= LATW'(1));
    endfunction

    assign srcok0 = src_ready(s0_use_ra, s0_ra) && src_ready(s0_use_rb, s0_rb)
                 && src_ready(s0_use_rc, s0_rc);
    assign srcok1 = src_ready(s1_use_ra, s1_ra) && src_ready(s1_use_rb, s1_rb)
                 && src_ready(s1_use_rc, s1_rc);

    assign lat0 = (s0_lat == '0) ? LATW'(1) : s0_lat;
    assign lat1 = (s1_lat == '0) ? LATW'(1) : s1_lat;

`ifdef SPU_SCHED_DUAL_ISSUE_EN
    logic raw_01, waw_01;
    assign raw_01 = s0_wr && ((s1_use_ra && s1_ra == s0_rt) || (s1_use_rb && s1_rb == s0_rt)
                           || (s1_use_rc && s1_rc == s0_rt));
    assign waw_01 = s0_wr && s1_wr && (s1_rt == s0_rt);
    assign pair_ok = (s1_pipe != s0_pipe) && srcok1 && !raw_01 && !waw_01;
`else
    assign pair_ok = 1'b0;
`endif

    // Issue decision and pair sequencing
    always_comb begin
        state_d    = state_q;
        iss0       = 1'b0;
        iss1       = 1'b0;
        in_ready   = 1'b0;
        if (flush) begin
            in_ready = in_valid;
            state_d  = FULL;
        end else begin
            case (state_q)
                FULL: begin
                    iss0     = in_valid && srcok0;
                    iss1     = iss0 && pair_ok;
                    in_ready = iss0 && iss1;
                    if (iss0 && !iss1) state_d = SECOND;
                end
                SECOND: begin
                    iss1     = in_valid && srcok1;
                    in_ready = iss1;
                    if (iss1) state_d = FULL;
                end
                default: state_d = FULL;
            endcase
        end
        even_issue = (iss0 && !s0_pipe) || (iss1 && !s1_pipe);
        even_slot  = iss1 && !s1_pipe;
        odd_issue  = (iss0 && s0_pipe) || (iss1 && s1_pipe);
        odd_slot   = iss1 && s1_pipe;
    end

    // Scoreboard: decrement toward zero, issued writers raise their entry to max(lat, cnt-1)
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            cnt_d[i] = (cnt_q[i] == '0) ? '0 : cnt_q[i] - LATW'(1);
            if (iss0 && s0_wr && s0_rt == AW'(i) && lat0 > cnt_d[i]) cnt_d[i] = lat0;
            if (iss1 && s1_wr && s1_rt == AW'(i) && lat1 > cnt_d[i]) cnt_d[i] = lat1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FULL;
            for (int unsigned i = 0; i < NREG; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_spu_issue_scheduler.sv
// Self-checking bench for spu_issue_scheduler: vector table, corner sequences, random vs. model.
module tb_spu_issue_scheduler;
    localparam int unsigned NREG = 128;
    localparam int unsigned LATW = 3;
`ifdef SPU_SCHED_DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    typedef struct packed {
        logic       pipe;
        logic [6:0] ra, rb, rc, rt;
        logic       ua, ub, uc, wr;
        logic [2:0] lat;
    } slot_t;

    typedef struct packed {
        logic       valid;
        logic       flush;
        slot_t      s0;
        slot_t      s1;
        logic [4:0] exp;   // {in_ready, even_issue, even_slot, odd_issue, odd_slot}
    } vec_t;

    logic clk = 1'b0;
    logic reset, flush, in_valid, in_ready;
    logic s0_pipe, s0_use_ra, s0_use_rb, s0_use_rc, s0_wr;
    logic s1_pipe, s1_use_ra, s1_use_rb, s1_use_rc, s1_wr;
    logic [6:0] s0_ra, s0_rb, s0_rc, s0_rt, s1_ra, s1_rb, s1_rc, s1_rt;
    logic [2:0] s0_lat, s1_lat;
    logic even_issue, even_slot, odd_issue, odd_slot;

    int checks = 0;
    int errors = 0;

    spu_issue_scheduler #(.NREG(NREG), .LATW(LATW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .s0_pipe(s0_pipe), .s0_ra(s0_ra), .s0_rb(s0_rb), .s0_rc(s0_rc), .s0_rt(s0_rt),
        .s0_use_ra(s0_use_ra), .s0_use_rb(s0_use_rb), .s0_use_rc(s0_use_rc),
        .s0_wr(s0_wr), .s0_lat(s0_lat),
        .s1_pipe(s1_pipe), .s1_ra(s1_ra), .s1_rb(s1_rb), .s1_rc(s1_rc), .s1_rt(s1_rt),
        .s1_use_ra(s1_use_ra), .s1_use_rb(s1_use_rb), .s1_use_rc(s1_use_rc),
        .s1_wr(s1_wr), .s1_lat(s1_lat),
        .even_issue(even_issue), .even_slot(even_slot),
        .odd_issue(odd_issue), .odd_slot(odd_slot)
    );

    always #5 clk = ~clk;

    function automatic slot_t mk(input logic pipe, input int rt, input logic wr, input int lat,
                                 input int ra, input logic ua);
        slot_t s;
        s      = '0;
        s.pipe = pipe;
        s.rt   = 7'(rt);
        s.wr   = wr;
        s.lat  = 3'(lat);
        s.ra   = 7'(ra);
        s.ua   = ua;
        return s;
    endfunction

    function automatic vec_t mkv(input logic v, input logic f, input slot_t a, input slot_t b,
                                 input logic [4:0] e);
        vec_t t;
        t.valid = v;
        t.flush = f;
        t.s0    = a;
        t.s1    = b;
        t.exp   = e;
        return t;
    endfunction

    function automatic logic [4:0] outs();
        return {in_ready, even_issue, even_slot, odd_issue, odd_slot};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input slot_t a, input slot_t b);
        in_valid = v;  flush = f;
        s0_pipe = a.pipe; s0_ra = a.ra; s0_rb = a.rb; s0_rc = a.rc; s0_rt = a.rt;
        s0_use_ra = a.ua; s0_use_rb = a.ub; s0_use_rc = a.uc; s0_wr = a.wr; s0_lat = a.lat;
        s1_pipe = b.pipe; s1_ra = b.ra; s1_rb = b.rb; s1_rc = b.rc; s1_rt = b.rt;
        s1_use_ra = b.ua; s1_use_rb = b.ub; s1_use_rc = b.uc; s1_wr = b.wr; s1_lat = b.lat;
    endtask

    // Advance to the next falling edge, apply inputs, settle
    task automatic step(input logic v, input logic f, input slot_t a, input slot_t b);
        @(negedge clk);
        drive(v, f, a, b);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference model: each register remembers the first cycle a reader may issue
    int  ready_at [NREG];
    bit  m_second;
    int  now;

    function automatic bit m_srcok(input slot_t s);
        return (!s.ua || now >= ready_at[s.ra]) && (!s.ub || now >= ready_at[s.rb])
            && (!s.uc || now >= ready_at[s.rc]);
    endfunction

    function automatic int m_cnt(input int r);
        int c;
        c = ready_at[r] - now + 1;
        return (c < 0) ? 0 : c;
    endfunction

    function automatic slot_t rnd_slot();
        slot_t s;
        s.pipe = 1'($urandom);
        s.ra = 7'($urandom_range(0, 7)); s.rb = 7'($urandom_range(0, 7));
        s.rc = 7'($urandom_range(0, 7)); s.rt = 7'($urandom_range(0, 7));
        s.ua = 1'($urandom); s.ub = 1'($urandom); s.uc = 1'($urandom);
        s.wr = 1'($urandom);
        s.lat = 3'($urandom_range(0, 7));
        return s;
    endfunction

    vec_t  tbl [18];
    slot_t nop_e, nop_o, a0, a1, b0, c0, c1, e0, f0, f1;

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        #1;
        check("reset_outs", int'(outs()), 0);
        check("reset_cnt", int'(dut.cnt_q[3]), 0);
        @(negedge clk);
        reset = 1'b0;

        nop_e = mk(1'b0, 0, 1'b0, 1, 0, 1'b0);
        nop_o = mk(1'b1, 0, 1'b0, 1, 0, 1'b0);
        a0 = mk(1'b0, 3, 1'b1, 3, 1, 1'b1);
        a1 = mk(1'b0, 4, 1'b1, 6, 5, 1'b1);
        b0 = mk(1'b1, 10, 1'b1, 1, 3, 1'b1);
        c0 = mk(1'b0, 20, 1'b1, 7, 0, 1'b0);
        c1 = mk(1'b0, 0, 1'b0, 1, 20, 1'b1);
        e0 = mk(1'b0, 0, 1'b0, 1, 20, 1'b1);
        f0 = mk(1'b0, 30, 1'b1, 0, 0, 1'b0);
        f1 = mk(1'b0, 0, 1'b0, 1, 30, 1'b1);

        tbl[0]  = mkv(1'b0, 1'b0, nop_e, nop_e, 5'b00000);
        tbl[1]  = mkv(1'b1, 1'b0, a0, a1, 5'b01000);
        tbl[2]  = mkv(1'b1, 1'b0, a0, a1, 5'b11100);
        tbl[3]  = mkv(1'b1, 1'b0, b0, nop_o, 5'b00000);
        tbl[4]  = mkv(1'b1, 1'b0, b0, nop_o, 5'b00010);
        tbl[5]  = mkv(1'b1, 1'b0, b0, nop_o, 5'b10011);
        tbl[6]  = mkv(1'b1, 1'b0, c0, c1, 5'b01000);
        tbl[7]  = mkv(1'b0, 1'b0, c0, c1, 5'b00000);
        tbl[8]  = mkv(1'b1, 1'b0, c0, c1, 5'b00000);
        tbl[9]  = mkv(1'b1, 1'b1, c0, c1, 5'b10000);
        tbl[10] = mkv(1'b1, 1'b0, nop_o, nop_o, 5'b00010);
        tbl[11] = mkv(1'b1, 1'b0, nop_o, nop_o, 5'b10011);
        tbl[12] = mkv(1'b1, 1'b0, e0, nop_e, 5'b00000);
        tbl[13] = mkv(1'b1, 1'b0, e0, nop_e, 5'b01000);
        tbl[14] = mkv(1'b1, 1'b0, e0, nop_e, 5'b11100);
        tbl[15] = mkv(1'b1, 1'b0, f0, f1, 5'b01000);
        tbl[16] = mkv(1'b1, 1'b0, f0, f1, 5'b11100);
        tbl[17] = mkv(1'b0, 1'b1, nop_e, nop_e, 5'b00000);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].valid, tbl[i].flush, tbl[i].s0, tbl[i].s1);
            check($sformatf("vec%0d", i), int'(outs()), int'(tbl[i].exp));
        end
        check("flush_cnt20", int'(dut.cnt_q[20]), 0);

        // Independent pair on different pipes
        do_reset();
        a0 = mk(1'b0, 3, 1'b1, 2, 1, 1'b1);
        a1 = mk(1'b1, 4, 1'b1, 6, 5, 1'b1);
        step(1'b1, 1'b0, a0, a1);
        if (DUAL) begin
            check("dual_c0", int'(outs()), 5'b11011);
            step(1'b0, 1'b0, a0, a1);
            check("dual_cnt3", int'(dut.cnt_q[3]), 2);
            check("dual_cnt4", int'(dut.cnt_q[4]), 6);
        end else begin
            check("single_c0", int'(outs()), 5'b01000);
            step(1'b1, 1'b0, a0, a1);
            check("single_c1", int'(outs()), 5'b10011);
            step(1'b0, 1'b0, a0, a1);
            check("single_cnt3", int'(dut.cnt_q[3]), 1);
            check("single_cnt4", int'(dut.cnt_q[4]), 6);
        end

        // Intra-pair RAW: slot 1 reads r9 written by slot 0 with latency 4
        a0 = mk(1'b0, 9, 1'b1, 4, 0, 1'b0);
        a1 = mk(1'b1, 11, 1'b0, 1, 9, 1'b1);
        step(1'b1, 1'b0, a0, a1);
        check("iraw_t0", int'(outs()), 5'b01000);
        for (int k = 1; k < 4; k++) begin
            step(1'b1, 1'b0, a0, a1);
            check($sformatf("iraw_t%0d", k), int'(outs()), 5'b00000);
        end
        step(1'b1, 1'b0, a0, a1);
        check("iraw_t4", int'(outs()), 5'b10011);

        // WAW on r7, then asynchronous reset while the entry is live
        do_reset();
        a0 = mk(1'b0, 7, 1'b1, 6, 0, 1'b0);
        a1 = mk(1'b0, 7, 1'b1, 2, 0, 1'b0);
        step(1'b1, 1'b0, a0, a1);
        check("waw_c0", int'(outs()), 5'b01000);
        step(1'b1, 1'b0, a0, a1);
        check("waw_c1", int'(outs()), 5'b11100);
        step(1'b0, 1'b0, a0, a1);
        check("waw_cnt7", int'(dut.cnt_q[7]), 5);
        #2 reset = 1'b1;
        #1;
        check("areset_cnt7", int'(dut.cnt_q[7]), 0);
        check("areset_outs", int'(outs()), 0);
        @(negedge clk);
        reset = 1'b0;

        // Random pairs against the model
        for (int r = 0; r < NREG; r++) ready_at[r] = -100;
        m_second = 1'b0;
        now = 0;
        begin
            slot_t rs0, rs1;
            bit    need_new, v, f, ok0, ok1, i0, i1, rdy, pair;
            logic [4:0] e;
            int    rr;
            need_new = 1'b1;
            rs0 = '0;
            rs1 = '0;
            for (int n = 0; n < 3000; n++) begin
                if (need_new) begin
                    rs0 = rnd_slot();
                    rs1 = rnd_slot();
                end
                v = ($urandom_range(0, 9) != 0);
                f = ($urandom_range(0, 19) == 0);
                step(v, f, rs0, rs1);
                ok0 = m_srcok(rs0);
                ok1 = m_srcok(rs1);
                i0 = 1'b0; i1 = 1'b0; rdy = 1'b0;
                if (f) begin
                    rdy = v;
                    m_second = 1'b0;
                end else if (!m_second) begin
                    pair = DUAL && rs0.pipe != rs1.pipe && ok1
                        && !(rs0.wr && ((rs1.ua && rs1.ra == rs0.rt) || (rs1.ub && rs1.rb == rs0.rt)
                                     || (rs1.uc && rs1.rc == rs0.rt)))
                        && !(rs0.wr && rs1.wr && rs0.rt == rs1.rt);
                    i0 = v && ok0;
                    i1 = i0 && pair;
                    rdy = i1;
                    m_second = i0 && !i1;
                end else begin
                    i1 = v && ok1;
                    rdy = i1;
                    m_second = !i1;
                end
                e = {rdy, (i0 && !rs0.pipe) || (i1 && !rs1.pipe), i1 && !rs1.pipe,
                     (i0 && rs0.pipe) || (i1 && rs1.pipe), i1 && rs1.pipe};
                check($sformatf("rand_out%0d", n), int'(outs()), int'(e));
                rr = $urandom_range(0, 7);
                check($sformatf("rand_cnt%0d_r%0d", n, rr), int'(dut.cnt_q[rr]), m_cnt(rr));
                if (i0 && rs0.wr && ready_at[rs0.rt] < now + ((rs0.lat == 0) ? 1 : int'(rs0.lat)))
                    ready_at[rs0.rt] = now + ((rs0.lat == 0) ? 1 : int'(rs0.lat));
                if (i1 && rs1.wr && ready_at[rs1.rt] < now + ((rs1.lat == 0) ? 1 : int'(rs1.lat)))
                    ready_at[rs1.rt] = now + ((rs1.lat == 0) ? 1 : int'(rs1.lat));
                need_new = rdy || !v;
                now++;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
